ne_hd_unload_ctrl: RTL and testbench

Single-clock, parametrised successor to the decoder output-interface unload path. After the decoder core signals completion, it walks the core's hard-decision memory by address and captures each KB-word row. It then streams the row out one HDW-bit word at a time with a valid/ready handshake. This adds downstream backpressure and configurable geometry, and sits between the decoder core's unload port and any downstream sink.

---
 rtl/ne_unload_pkg.sv | 21 ++
 rtl/ne_hd_row_buffer.sv | 41 ++++
 rtl/ne_hd_unload_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ne_hd_unload_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ne_unload_pkg.sv
// Shared constants for the decoder hard-decision unload path: state encoding
// and the default frame geometry used by the output interface.
package ne_unload_pkg;

  localparam int DEF_KB           = 14;
  localparam int DEF_HDW          = 32;
  localparam int DEF_UNLOADCOUNT  = 17;
  localparam int DEF_ADDRESSWIDTH = 5;
  localparam int DEF_RDLAT        = 2;
  localparam int DEF_KBW          = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAP  = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } unload_state_e;

endpackage

// File: rtl/ne_hd_row_buffer.sv
// KB*HDW row capture register (one buffer, or two for ping-pong) with a word
// select mux. NBUF=2 is used when UNLOAD_PREFETCH_EN is defined in the top.
module ne_hd_row_buffer #(
  parameter int KB   = 14,
  parameter int HDW  = 32,
  parameter int KBW  = 4,
  parameter int NBUF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              cap_sel,
  input  logic [KB*HDW-1:0] din,
  input  logic              rd_sel,
  input  logic [KBW-1:0]    word_sel,
  output logic [HDW-1:0]    dout
);

  logic [NBUF-1:0][KB*HDW-1:0] row_q;
  logic [KB*HDW-1:0]           row_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
    end else if (cap_en) begin
      for (int b = 0; b < NBUF; b++)
        if (NBUF == 1 || cap_sel == b[0]) row_q[b] <= din;
    end
  end

  if (NBUF == 1) begin : g_single
    logic unused_sel;
    assign unused_sel = rd_sel;
    assign row_rd     = row_q[0];
  end else begin : g_pingpong
    assign row_rd = row_q[rd_sel];
  end

  assign dout = row_rd[word_sel*HDW +: HDW];

endmodule

// File: rtl/ne_hd_unload_ctrl.sv
// Walks the decoder hard-decision memory row by row and streams each row out
// as HDW-bit words over valid/ready. UNLOAD_PREFETCH_EN adds a ping-pong row
// buffer so the next row is read while the current one drains.
module ne_hd_unload_ctrl
  import ne_unload_pkg::*;
#(
  parameter int KB           = DEF_KB,
  parameter int HDW          = DEF_HDW,
  parameter int UNLOADCOUNT  = DEF_UNLOADCOUNT,
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int RDLAT        = DEF_RDLAT,
  parameter int KBW          = DEF_KBW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    unload_start,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unload_addr,
  input  logic [KB*HDW-1:0]       hd_vec_in,
  output logic [HDW-1:0]          hd_out,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    start_dropped
);

  localparam int AW = ADDRESSWIDTH;
`ifdef UNLOAD_PREFETCH_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  unload_state_e    state;
  logic [AW-1:0]    addr_cnt;
  logic [KBW-1:0]   word_cnt;
  logic [2:0]       wait_cnt;
  logic [RDLAT-1:0] vld_pipe;
  logic             cap_fire, accept, last_word, last_addr, avail;
  logic             rd_sel, wr_sel;

  // vld_pipe tracks each issued read so capture lands exactly RDLAT cycles on
  assign cap_fire  = vld_pipe[RDLAT-1];
  assign accept    = hd_valid & hd_ready;
  assign last_word = (word_cnt == KBW'(KB-1));
  assign last_addr = (addr_cnt == AW'(UNLOADCOUNT-1));

`ifdef UNLOAD_PREFETCH_EN
  logic pf_landed, row_next;

  assign avail    = pf_landed | cap_fire;
  assign row_next = (state == ST_CAP && avail) ||
                    (accept && last_word && !last_addr && avail);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_landed <= 1'b0;
      rd_sel    <= 1'b0;
      wr_sel    <= 1'b0;
    end else if (state == ST_DONE) begin
      pf_landed <= 1'b0;
      rd_sel    <= 1'b0;
      wr_sel    <= 1'b0;
    end else begin
      pf_landed <= avail & ~row_next;
      if (cap_fire) wr_sel <= ~wr_sel;
      if (accept && last_word && !last_addr) rd_sel <= ~rd_sel;
    end
  end
`else
  assign avail  = cap_fire;
  assign rd_sel = 1'b0;
  assign wr_sel = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr_cnt      <= '0;
      word_cnt      <= '0;
      wait_cnt      <= '0;
      vld_pipe      <= '0;
      unload_en     <= 1'b0;
      unload_addr   <= '0;
      hd_valid      <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      vld_pipe   <= RDLAT'({vld_pipe, unload_en});
      unload_en  <= 1'b0;
      frame_done <= 1'b0;
      if (unload_start && state != ST_IDLE) start_dropped <= 1'b1;
      case (state)
        ST_IDLE: if (unload_start) begin
          state       <= ST_REQ;
          busy        <= 1'b1;
          unload_en   <= 1'b1;
          unload_addr <= addr_cnt;
        end
        ST_REQ: begin
          wait_cnt <= '0;
          state    <= (RDLAT == 1) ? ST_CAP : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'(RDLAT-2)) state <= ST_CAP;
          else                         wait_cnt <= wait_cnt + 1'b1;
        end
        // with prefetch, CAP also parks here when a row ends before its successor landed
        ST_CAP: if (avail) begin
          state    <= ST_EMIT;
          hd_valid <= 1'b1;
`ifdef UNLOAD_PREFETCH_EN
          if (!last_addr) begin
            unload_en   <= 1'b1;
            unload_addr <= AW'(addr_cnt + 1);
          end
`endif
        end
        ST_EMIT: if (accept) begin
          if (!last_word) begin
            word_cnt <= word_cnt + 1'b1;
          end else begin
            word_cnt <= '0;
            if (last_addr) begin
              state      <= ST_DONE;
              hd_valid   <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
`ifdef UNLOAD_PREFETCH_EN
              if (avail) begin
                if (AW'(addr_cnt + 1) != AW'(UNLOADCOUNT-1)) begin
                  unload_en   <= 1'b1;
                  unload_addr <= AW'(addr_cnt + 2);
                end
              end else begin
                state    <= ST_CAP;
                hd_valid <= 1'b0;
              end
`else
              state       <= ST_REQ;
              hd_valid    <= 1'b0;
              unload_en   <= 1'b1;
              unload_addr <= AW'(addr_cnt + 1);
`endif
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          addr_cnt <= '0;
          word_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ne_hd_row_buffer #(
    .KB(KB), .HDW(HDW), .KBW(KBW), .NBUF(NBUF)
  ) u_row_buf (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_fire),
    .cap_sel  (wr_sel),
    .din      (hd_vec_in),
    .rd_sel   (rd_sel),
    .word_sel (word_cnt),
    .dout     (hd_out)
  );

endmodule

// File: tb/tb_ne_hd_unload_ctrl.sv
// Bench for ne_hd_unload_ctrl: default-geometry DUT plus a small
// RDLAT=1/KB=4/UNLOADCOUNT=3 DUT, each fed by a latency-accurate memory model.
module tb_ne_hd_unload_ctrl;

  logic         clk, rst;
  logic         unload_start, unload_en, hd_valid, hd_ready, frame_done, busy, start_dropped;
  logic [4:0]   unload_addr;
  logic [447:0] hd_vec_in, junk;
  logic [31:0]  hd_out;

  logic         unload_start_s, unload_en_s, hd_valid_s, hd_ready_s, frame_done_s, busy_s, start_dropped_s;
  logic [1:0]   unload_addr_s;
  logic [127:0] hd_vec_s;
  logic [447:0] row_main, row_small;
  logic [31:0]  hd_out_s;

  int nchk, nerr;
  logic [31:0] got_q[$], exp_q[$];
  logic [4:0]  en_q[$];
  int fd_cnt, fd_cyc, fv_cyc;
  bit busy_at0;

  ne_hd_unload_ctrl dut (
    .clk(clk), .rst(rst), .unload_start(unload_start), .unload_en(unload_en),
    .unload_addr(unload_addr), .hd_vec_in(hd_vec_in), .hd_out(hd_out), .hd_valid(hd_valid),
    .hd_ready(hd_ready), .frame_done(frame_done), .busy(busy), .start_dropped(start_dropped)
  );

  ne_hd_unload_ctrl #(.KB(4), .HDW(32), .UNLOADCOUNT(3), .ADDRESSWIDTH(2), .RDLAT(1), .KBW(2)) dut_s (
    .clk(clk), .rst(rst), .unload_start(unload_start_s), .unload_en(unload_en_s),
    .unload_addr(unload_addr_s), .hd_vec_in(hd_vec_s), .hd_out(hd_out_s), .hd_valid(hd_valid_s),
    .hd_ready(hd_ready_s), .frame_done(frame_done_s), .busy(busy_s), .start_dropped(start_dropped_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [447:0] row_of(input logic [4:0] a);
    logic [447:0] r;
    r = '0;
    for (int k = 0; k < 14; k++) r[k*32 +: 32] = {11'd0, a, 16'(k)};
    return r;
  endfunction

  // Memory model: row for an address appears RDLAT cycles after the strobe, junk otherwise
  logic [1:0] mv;
  logic [4:0] ma0, ma1;
  logic       mv_s;
  logic [1:0] ma_s;
  always @(posedge clk) begin
    mv   <= {mv[0], unload_en};
    ma0  <= unload_addr;
    ma1  <= ma0;
    mv_s <= unload_en_s;
    ma_s <= unload_addr_s;
    for (int i = 0; i < 14; i++) junk[i*32 +: 32] <= $urandom;
  end
  assign row_main  = row_of(ma1);
  assign row_small = row_of({3'd0, ma_s});
  assign hd_vec_in = mv[1] ? row_main : junk;
  assign hd_vec_s  = mv_s ? row_small[127:0] : junk[127:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    int bad, abad;
    bad = -1; abad = -1;
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (got_q[i]) if (bad < 0 && (i >= exp_q.size() || got_q[i] !== exp_q[i])) bad = i;
    chk({tag, "_order"}, 32'(bad), 32'hffff_ffff);
    chk({tag, "_nreads"}, 32'(en_q.size()), 32'd17);
    foreach (en_q[i]) if (abad < 0 && en_q[i] !== 5'(i)) abad = i;
    chk({tag, "_read_addrs"}, 32'(abad), 32'hffff_ffff);
    chk({tag, "_frame_done_cnt"}, 32'(fd_cnt), 32'd1);
  endtask

  // One frame on the main DUT; n=0 is the first cycle after start is sampled
  task automatic run_frame(input int rdy_pct, input int drop_at, input int rst_word);
    logic [31:0] held;
    bit stalled;
    got_q.delete(); en_q.delete();
    fd_cnt = 0; fd_cyc = -1; fv_cyc = -1; stalled = 0; held = '0;
    unload_start = 1'b1;
    @(negedge clk);
    unload_start = 1'b0;
    busy_at0 = busy;
    for (int n = 0; n < 3000; n++) begin
      if (rst_word > 0 && got_q.size() == rst_word) begin
        rst = 1'b1;
        #1;
        chk("rst_hd_valid", 32'(hd_valid), 32'd0);
        chk("rst_hd_out", hd_out, 32'd0);
        chk("rst_unload_en", 32'(unload_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start_dropped", 32'(start_dropped), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      hd_ready     = ($urandom_range(99) < 32'(rdy_pct));
      unload_start = (n == drop_at);
      if (stalled) begin
        chk("stall_valid", 32'(hd_valid), 32'd1);
        chk("stall_hold", hd_out, held);
      end
      if (unload_en) en_q.push_back(unload_addr);
      if (frame_done) begin
        fd_cnt++;
        if (fd_cyc < 0) fd_cyc = n;
      end
      if (hd_valid && fv_cyc < 0) fv_cyc = n;
      stalled = hd_valid && !hd_ready;
      held    = hd_out;
      if (hd_valid && hd_ready) got_q.push_back(hd_out);
      if (fd_cnt > 0 && n >= fd_cyc + 20) break;
      @(negedge clk);
    end
    unload_start = 1'b0;
  endtask

  initial begin
    int sfd, sfd_cyc, sbad;
    logic [31:0] s_got[$];
    logic [1:0]  s_en[$];
    nchk = 0; nerr = 0;
    rst = 1'b1; unload_start = 1'b0; hd_ready = 1'b0;
    unload_start_s = 1'b0; hd_ready_s = 1'b1;
    for (int a = 0; a < 17; a++)
      for (int k = 0; k < 14; k++) exp_q.push_back({16'(a), 16'(k)});
    repeat (3) @(negedge clk);
    chk("reset_hd_valid", 32'(hd_valid), 32'd0);
    chk("reset_hd_out", hd_out, 32'd0);
    chk("reset_unload_en", 32'(unload_en), 32'd0);
    chk("reset_unload_addr", 32'(unload_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_start_dropped", 32'(start_dropped), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-rate frame: latency, order, end timing
    run_frame(100, -1, -1);
    check_stream("f1");
    chk("f1_busy_at_start", 32'(busy_at0), 32'd1);
    chk("f1_first_valid_cycle", 32'(fv_cyc), 32'd3);
    chk("f1_first_word", got_q.size() > 0 ? got_q[0] : 32'hdead_beef, 32'h0000_0000);
    chk("f1_last_word", got_q.size() > 0 ? got_q[got_q.size()-1] : 32'hdead_beef, 32'h0010_000d);
`ifdef UNLOAD_PREFETCH_EN
    chk("f1_frame_done_cycle", 32'(fd_cyc), 32'd241);
`else
    chk("f1_frame_done_cycle", 32'(fd_cyc), 32'(17 * (2 + 1 + 14)));
`endif
    chk("f1_busy_after", 32'(busy), 32'd0);

    // Random backpressure
    run_frame(50, -1, -1);
    check_stream("f2");

    // Extra start mid-frame is dropped and sticky
    run_frame(100, 40, -1);
    check_stream("f3");
    chk("f3_start_dropped", 32'(start_dropped), 32'd1);
    chk("f3_idle_valid", 32'(hd_valid), 32'd0);
    chk("f3_idle_busy", 32'(busy), 32'd0);

    // Reset mid-frame, then a clean frame from address 0
    run_frame(100, -1, 100);
    run_frame(100, -1, -1);
    check_stream("f4");
    chk("f4_start_dropped", 32'(start_dropped), 32'd0);

    // Small geometry DUT
    unload_start_s = 1'b1;
    @(negedge clk);
    unload_start_s = 1'b0;
    sfd = 0; sfd_cyc = -1; sbad = -1;
    for (int n = 0; n < 60; n++) begin
      if (unload_en_s) s_en.push_back(unload_addr_s);
      if (hd_valid_s) s_got.push_back(hd_out_s);
      if (frame_done_s) begin
        sfd++;
        if (sfd_cyc < 0) sfd_cyc = n;
      end
      @(negedge clk);
    end
    chk("s_nwords", 32'(s_got.size()), 32'd12);
    foreach (s_got[i]) if (sbad < 0 && s_got[i] !== {16'(i / 4), 16'(i % 4)}) sbad = i;
    chk("s_order", 32'(sbad), 32'hffff_ffff);
    chk("s_nreads", 32'(s_en.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("s_read_addr", i < s_en.size() ? 32'(s_en[i]) : 32'hdead_beef, 32'(i));
    chk("s_frame_done_cnt", 32'(sfd), 32'd1);
`ifdef UNLOAD_PREFETCH_EN
    chk("s_frame_done_cycle", 32'(sfd_cyc), 32'd14);
`else
    chk("s_frame_done_cycle", 32'(sfd_cyc), 32'd18);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
